// File: rtl/mc_control_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_if
// Purpose  : Control bundle between the multi-cycle MIPS main control FSM and
//            the datapath / memory it sequences.
// Ports    : opcode, mem_ready           - into the FSM (IR field, memory)
//            mem_req .. RegWrite         - datapath strobes and mux selects
//            halted, state               - status / debug
// Revision : 1.0 - initial release
// ============================================================================
interface mc_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNE;
  logic [1:0] PCSource;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtZero;
  logic [3:0] ALUOp;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       halted;
  logic [3:0] state;

  // master: the control FSM
  modport master (
    input  opcode, mem_ready,
    output mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
           BranchNE, PCSource, ALUSrcA, ALUSrcB, ExtZero, ALUOp, RegDst,
           MemtoReg, RegWrite, halted, state
  );

  // slave: the datapath side
  modport slave (
    output opcode, mem_ready,
    input  mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
           BranchNE, PCSource, ALUSrcA, ALUSrcB, ExtZero, ALUOp, RegDst,
           MemtoReg, RegWrite, halted, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Multi-cycle MIPS main control FSM. Sequences fetch, decode,
//            execute, memory and writeback, driving every datapath select,
//            write enable and the 4-bit ALUOp for the ALU control decoder.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - mc_control_if.master (opcode/mem_ready in, controls out)
// Params   : ILLEGAL_HALT - 1: unknown opcode halts; 0: treated as NOP
// Revision : 1.0 - initial release
// ============================================================================
module mc_control #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    EXEC_I    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    HALT      = 4'd12
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  state_t     r_state;
  state_t     w_next;

  // Registered control word, loaded with the values belonging to the state
  // being entered so every output is a flop.
  logic       r_mem_req, r_mem_read, r_mem_write, r_iord;
  logic       r_fetch_stb;   // FETCH-only IR/PC load, qualified by mem_ready
  logic       r_pc_write_j;  // unconditional PC load in JUMP
  logic       r_pc_write_cond, r_branch_ne;
  logic [1:0] r_pc_source;
  logic       r_alu_src_a;
  logic [1:0] r_alu_src_b;
  logic       r_ext_zero;
  logic [3:0] r_alu_op;
  logic       r_reg_dst, r_mem_to_reg, r_reg_write, r_halted;

  logic       w_mem_req, w_mem_read, w_mem_write, w_iord;
  logic       w_fetch_stb, w_pc_write_j, w_pc_write_cond, w_branch_ne;
  logic [1:0] w_pc_source;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_ext_zero;
  logic [3:0] w_alu_op;
  logic       w_reg_dst, w_mem_to_reg, w_reg_write, w_halted;

  logic       w_fetch_load;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:     w_next = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (bus.opcode == c_op_lw || bus.opcode == c_op_sw)
          w_next = MEM_ADDR;
        else if (bus.opcode == c_op_rtype)
          w_next = EXEC_R;
        else if (bus.opcode == c_op_beq || bus.opcode == c_op_bne)
          w_next = BRANCH;
        else if (bus.opcode == c_op_j)
          w_next = JUMP;
        else if (bus.opcode[5:3] == 3'b001)   // 0x08..0x0F immediate ops
          w_next = EXEC_I;
        else
          w_next = ILLEGAL_HALT ? HALT : FETCH;
      end
      MEM_ADDR:  w_next = (bus.opcode == c_op_lw) ? MEM_READ : MEM_WRITE;
      MEM_READ:  w_next = bus.mem_ready ? MEM_WB : MEM_READ;
      MEM_WB:    w_next = FETCH;
      MEM_WRITE: w_next = bus.mem_ready ? FETCH : MEM_WRITE;
      EXEC_R:    w_next = R_WB;
      R_WB:      w_next = FETCH;
      EXEC_I:    w_next = I_WB;
      I_WB:      w_next = FETCH;
      BRANCH:    w_next = FETCH;
      JUMP:      w_next = FETCH;
      HALT:      w_next = HALT;
      default:   w_next = FETCH;
    endcase
  end

  // Control word for the state being entered. The opcode is stable from
  // DECODE onward, so opcode-dependent fields can be captured on entry.
  always_comb begin
    w_mem_req       = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_iord          = 1'b0;
    w_fetch_stb     = 1'b0;
    w_pc_write_j    = 1'b0;
    w_pc_write_cond = 1'b0;
    w_branch_ne     = 1'b0;
    w_pc_source     = 2'b00;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_ext_zero      = 1'b0;
    w_alu_op        = 4'b0000;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_halted        = 1'b0;
    case (w_next)
      FETCH: begin
        w_mem_req   = 1'b1;
        w_mem_read  = 1'b1;
        w_fetch_stb = 1'b1;
        w_alu_src_b = 2'b01;
        w_alu_op    = 4'b0010;
      end
      DECODE: begin
        w_alu_src_b = 2'b11;
        w_alu_op    = 4'b0010;
      end
      MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = 4'b0010;
      end
      MEM_READ: begin
        w_mem_req  = 1'b1;
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      EXEC_R: begin
        w_alu_src_a = 1'b1;
      end
      R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_ext_zero  = bus.opcode[2];   // andi/ori/xori/lui zero-extend
        case (bus.opcode[2:0])
          3'd0:    w_alu_op = 4'b0010;  // addi
          3'd1:    w_alu_op = 4'b0100;  // addiu
          3'd2:    w_alu_op = 4'b0101;  // slti
          3'd3:    w_alu_op = 4'b0110;  // sltiu
          3'd4:    w_alu_op = 4'b0111;  // andi
          3'd5:    w_alu_op = 4'b1000;  // ori
          3'd6:    w_alu_op = 4'b1001;  // xori
          default: w_alu_op = 4'b0011;  // lui
        endcase
      end
      I_WB: begin
        w_reg_write = 1'b1;
      end
      BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 4'b0001;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_branch_ne     = (bus.opcode == c_op_bne);
      end
      JUMP: begin
        w_pc_write_j = 1'b1;
        w_pc_source  = 2'b10;
      end
      HALT: begin
        w_halted = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset loads the FETCH control word; the fetch strobes are additionally
  // masked by rst at the outputs so nothing requests memory while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= FETCH;
      r_mem_req       <= 1'b1;
      r_mem_read      <= 1'b1;
      r_mem_write     <= 1'b0;
      r_iord          <= 1'b0;
      r_fetch_stb     <= 1'b1;
      r_pc_write_j    <= 1'b0;
      r_pc_write_cond <= 1'b0;
      r_branch_ne     <= 1'b0;
      r_pc_source     <= 2'b00;
      r_alu_src_a     <= 1'b0;
      r_alu_src_b     <= 2'b01;
      r_ext_zero      <= 1'b0;
      r_alu_op        <= 4'b0010;
      r_reg_dst       <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_reg_write     <= 1'b0;
      r_halted        <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_mem_req       <= w_mem_req;
      r_mem_read      <= w_mem_read;
      r_mem_write     <= w_mem_write;
      r_iord          <= w_iord;
      r_fetch_stb     <= w_fetch_stb;
      r_pc_write_j    <= w_pc_write_j;
      r_pc_write_cond <= w_pc_write_cond;
      r_branch_ne     <= w_branch_ne;
      r_pc_source     <= w_pc_source;
      r_alu_src_a     <= w_alu_src_a;
      r_alu_src_b     <= w_alu_src_b;
      r_ext_zero      <= w_ext_zero;
      r_alu_op        <= w_alu_op;
      r_reg_dst       <= w_reg_dst;
      r_mem_to_reg    <= w_mem_to_reg;
      r_reg_write     <= w_reg_write;
      r_halted        <= w_halted;
    end
  end

  // IR and PC load in FETCH only once memory delivers the instruction.
  assign w_fetch_load    = r_fetch_stb & bus.mem_ready & ~rst;

  assign bus.mem_req     = r_mem_req & ~rst;
  assign bus.MemRead     = r_mem_read & ~rst;
  assign bus.MemWrite    = r_mem_write;
  assign bus.IorD        = r_iord;
  assign bus.IRWrite     = w_fetch_load;
  assign bus.PCWrite     = w_fetch_load | r_pc_write_j;
  assign bus.PCWriteCond = r_pc_write_cond;
  assign bus.BranchNE    = r_branch_ne;
  assign bus.PCSource    = r_pc_source;
  assign bus.ALUSrcA     = r_alu_src_a;
  assign bus.ALUSrcB     = r_alu_src_b;
  assign bus.ExtZero     = r_ext_zero;
  assign bus.ALUOp       = r_alu_op;
  assign bus.RegDst      = r_reg_dst;
  assign bus.MemtoReg    = r_mem_to_reg;
  assign bus.RegWrite    = r_reg_write;
  assign bus.halted      = r_halted;
  assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle MIPS main control FSM. It sequences the shared ALU, register file, memory port and PC across the fetch, decode, execute, memory and writeback steps.
- It decodes the IR opcode and drives the 4-bit ALUOp that feeds the ALU control decoder.
- It also drives every datapath mux select and write enable.
- It sits between the instruction register and the multi-cycle datapath.

Parameters:
- ILLEGAL_HALT, 1, 1: an unknown opcode enters HALT permanently. 0: an unknown opcode is treated as a NOP and the FSM returns to FETCH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- MemRead  out  1  read strobe
- MemWrite  out  1  write strobe
- IorD  out  1  address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load the IR
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  conditional PC load for branches
- BranchNE  out  1  1 = branch on !zero (bne), 0 = branch on zero (beq)
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
- ExtZero  out  1  1 = zero-extend the immediate, 0 = sign-extend
- ALUOp  out  4  to the ALU control decoder
- RegDst  out  1  1 = rd, 0 = rt
- MemtoReg  out  1  1 = MDR, 0 = ALUOut
- RegWrite  out  1  register file write enable
- halted  out  1  FSM is in HALT
- state  out  4  current state, for debug

Behaviour:
- Reset: asynchronous. The FSM enters FETCH. Every output is 0 during reset except ALUSrcB=01 and ALUOp=0010, which are the FETCH defaults. State encoding is FETCH=0.
- All outputs are decoded from the current state only (Moore), with one exception: IRWrite and PCWrite in FETCH are ANDed with mem_ready.
- In any state, outputs not listed below are 0.
- ALUOp encoding:
  - 0000 R-type (funct decoded downstream)
  - 0001 sub
  - 0010 add
  - 0011 lui pass-through
  - 0100 addiu
  - 0101 slti
  - 0110 sltiu
  - 0111 andi
  - 1000 ori
  - 1001 xori
- States and outputs:
  - FETCH: mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0010, PCSource=00. IRWrite and PCWrite are set only when mem_ready=1. Stay in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ExtZero=0, ALUOp=0010 (branch target computed into ALUOut). Next state by opcode:
    - 0x23 / 0x2B -> MEM_ADDR
    - 0x00 -> EXEC_R
    - 0x04 / 0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x08–0x0F -> EXEC_I
    - anything else -> HALT if ILLEGAL_HALT=1, else FETCH
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=0010. Goes to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: mem_req=1, MemRead=1, IorD=1. Waits for mem_ready, then goes to MEM_WB.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
  - MEM_WRITE: mem_req=1, MemWrite=1, IorD=1. Waits for mem_ready, then goes to FETCH.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=0000. Goes to R_WB.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
  - EXEC_I: ALUSrcA=1, ALUSrcB=10. ALUOp and ExtZero by opcode:
    - 0x08 addi: 0010, ExtZero=0
    - 0x09 addiu: 0100, ExtZero=0
    - 0x0A slti: 0101, ExtZero=0
    - 0x0B sltiu: 0110, ExtZero=0
    - 0x0C andi: 0111, ExtZero=1
    - 0x0D ori: 1000, ExtZero=1
    - 0x0E xori: 1001, ExtZero=1
    - 0x0F lui: 0011, ExtZero=1
    - Goes to I_WB.
  - I_WB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0001, PCWriteCond=1, PCSource=01, BranchNE=(opcode==0x05). Goes to FETCH.
  - JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
  - HALT: all strobes 0, halted=1. Left only by rst.
- Latency with mem_ready tied high:
  - lw: 5 cycles
  - sw, R-type, I-type: 4 cycles
  - beq, bne, j: 3 cycles
  - Each cycle with mem_ready=0 in a memory state adds one cycle.
- The opcode is sampled from DECODE onward. The IR holds it stable, so no internal copy is kept.
- Reset mid-instruction: the FSM returns to FETCH immediately. No RegWrite, MemWrite or PCWrite pulse may appear after rst rises.
- mem_ready outside the memory states is ignored.
- MemRead and MemWrite are never high together. RegWrite and any PC write are never high together.

Test Plan:
- rst pulse mid-EXEC_R -> state=FETCH immediately (asynchronously), RegWrite stays 0. After release, the FETCH sequence restarts with ALUSrcB=01, ALUOp=0010.
- lw (opcode 0x23), mem_ready=1 -> states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB over 5 cycles. Exactly one RegWrite pulse, with MemtoReg=1, RegDst=0.
- sw (opcode 0x2B), mem_ready held low 3 cycles in MEM_WRITE -> MemWrite=1 for 4 cycles, no RegWrite, back in FETCH on the cycle after ready.
- R-type (opcode 0x00) then ori (opcode 0x0D):
  - R-type -> ALUOp=0000 in EXEC_R, RegDst=1.
  - ori -> ALUOp=1000, ExtZero=1 in EXEC_I, RegDst=0.
  - Each instruction takes 4 cycles.
- bne (opcode 0x05) -> BRANCH state with ALUOp=0001, PCWriteCond=1, BranchNE=1, PCSource=01, 3 cycles total. beq (0x04) gives the same except BranchNE=0.
- opcode 0x3F with ILLEGAL_HALT=1 -> halted=1 from the cycle after DECODE, no further strobes. With ILLEGAL_HALT=0 -> back to FETCH with no writes.
